// File: rtl/wb_writer_pkg.sv
// Shared CPU definitions used by the write-back stage: register file geometry
// and the queued mul/div result entry.
package wb_writer_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;
  localparam int NUM_REGS   = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] dest;
    logic [DATA_W-1:0]     data;
    logic [DATA_W-1:0]     pc;
    logic                  live;
  } wb_entry_t;

  function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] r);
    reg_onehot = {{(NUM_REGS-1){1'b0}}, 1'b1} << r;
  endfunction

endpackage

// File: rtl/wb_writer_if.sv
// Write-back bus: single-cycle pipe results, mul/div handshake and the
// register-file write port with the pending-write scoreboard.
interface wb_writer_if;
  import wb_writer_pkg::*;

  logic                  pipe_valid;
  logic [REG_ADDR_W-1:0] pipe_reg;
  logic [DATA_W-1:0]     pipe_data;
  logic [DATA_W-1:0]     pipe_pc;
  logic                  md_valid;
  logic                  md_ready;
  logic [REG_ADDR_W-1:0] md_reg;
  logic [DATA_W-1:0]     md_data;
  logic [DATA_W-1:0]     md_pc;
  logic                  regwrite;
  logic [REG_ADDR_W-1:0] write_reg;
  logic [DATA_W-1:0]     write_data;
  logic [DATA_W-1:0]     pc_new;
  logic [NUM_REGS-1:0]   busy;

  modport master (
    output pipe_valid, pipe_reg, pipe_data, pipe_pc,
    output md_valid, md_reg, md_data, md_pc,
    input  md_ready, regwrite, write_reg, write_data, pc_new, busy
  );

  modport slave (
    input  pipe_valid, pipe_reg, pipe_data, pipe_pc,
    input  md_valid, md_reg, md_data, md_pc,
    output md_ready, regwrite, write_reg, write_data, pc_new, busy
  );

endinterface

// File: rtl/wb_queue.sv
// Circular buffer of pending mul/div writes with per-entry write-after-write
// cancel by destination and a derived pending-register mask.
module wb_queue
  import wb_writer_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = PTR_W + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enq,
  input  wb_entry_t             enq_entry,
  input  logic                  deq,
  input  logic                  cancel_en,
  input  logic [REG_ADDR_W-1:0] cancel_reg,
  output wb_entry_t             head,
  output logic [CNT_W-1:0]      count,
  output logic                  full,
  output logic                  empty,
  output logic [NUM_REGS-1:0]   busy
);

  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  wb_entry_t          mem_r [DEPTH];
  logic [PTR_W-1:0]   rd_ptr_r;
  logic [PTR_W-1:0]   wr_ptr_r;
  logic [CNT_W-1:0]   count_r;
  logic [NUM_REGS-1:0] busy_s;

  // Storage update: cancel first, then retire head, then write the new (younger) entry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr_r <= {PTR_W{1'b0}};
      wr_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (cancel_en && (mem_r[i].dest == cancel_reg)) mem_r[i].live <= 1'b0;
      end
      if (deq) begin
        mem_r[rd_ptr_r].live <= 1'b0;
        rd_ptr_r             <= rd_ptr_r + PTR_ONE;
      end
      if (enq) begin
        mem_r[wr_ptr_r] <= enq_entry;
        wr_ptr_r        <= wr_ptr_r + PTR_ONE;
      end
      case ({enq, deq})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Pending mask: only occupied slots can hold a live bit.
  always_comb begin
    busy_s = {NUM_REGS{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      if (mem_r[i].live) busy_s = busy_s | reg_onehot(mem_r[i].dest);
      else               busy_s = busy_s;
    end
  end

  assign head  = mem_r[rd_ptr_r];
  assign count = count_r;
  assign full  = (count_r == CNT_W'(DEPTH));
  assign empty = (count_r == {CNT_W{1'b0}});
  assign busy  = busy_s;

endmodule

// File: rtl/wb_writer.sv
// Register-file write-back arbiter: pipe results win, mul/div results queue.
// Optional trace output is enabled with WB_WRITER_TRACE_EN.
module wb_writer
  import wb_writer_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic      clk,
  input  logic      reset,
  wb_writer_if.slave bus
);

  localparam int CNT_W = ((FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1) + 1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic                  enq_s;
  logic                  deq_s;
  logic                  cancel_en_s;
  wb_entry_t             enq_entry_s;
  wb_entry_t             head_s;
  logic [CNT_W-1:0]      count_s;
  logic [CNT_W-1:0]      next_count_s;
  logic                  full_s;
  logic                  empty_s;
  logic [NUM_REGS-1:0]   busy_s;
  logic                  md_ready_r;
  logic                  regwrite_r;
  logic [REG_ADDR_W-1:0] write_reg_r;
  logic [DATA_W-1:0]     write_data_r;
  logic [DATA_W-1:0]     pc_new_r;

  // Queue control; register 0 transfers are accepted but never enqueued.
  always_comb begin
    enq_s        = bus.md_valid & md_ready_r & ~full_s & (bus.md_reg != {REG_ADDR_W{1'b0}});
    deq_s        = ~bus.pipe_valid & ~empty_s;
    cancel_en_s  = bus.pipe_valid & (bus.pipe_reg != {REG_ADDR_W{1'b0}});
    enq_entry_s  = '{dest: bus.md_reg, data: bus.md_data, pc: bus.md_pc, live: 1'b1};
    case ({enq_s, deq_s})
      2'b10:   next_count_s = count_s + CNT_ONE;
      2'b01:   next_count_s = count_s - CNT_ONE;
      default: next_count_s = count_s;
    endcase
  end

  wb_queue #(.DEPTH(FIFO_DEPTH)) u_queue (
    .clk        (clk),
    .reset      (reset),
    .enq        (enq_s),
    .enq_entry  (enq_entry_s),
    .deq        (deq_s),
    .cancel_en  (cancel_en_s),
    .cancel_reg (bus.pipe_reg),
    .head       (head_s),
    .count      (count_s),
    .full       (full_s),
    .empty      (empty_s),
    .busy       (busy_s)
  );

  // Write port and ready flag; ready is registered so it stays low through reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      md_ready_r   <= 1'b0;
      regwrite_r   <= 1'b0;
      write_reg_r  <= {REG_ADDR_W{1'b0}};
      write_data_r <= {DATA_W{1'b0}};
      pc_new_r     <= {DATA_W{1'b0}};
    end else begin
      md_ready_r <= (next_count_s < CNT_W'(FIFO_DEPTH));
      if (bus.pipe_valid) begin
        regwrite_r   <= (bus.pipe_reg != {REG_ADDR_W{1'b0}});
        write_reg_r  <= bus.pipe_reg;
        write_data_r <= bus.pipe_data;
        pc_new_r     <= bus.pipe_pc;
      end else if (!empty_s) begin
        regwrite_r   <= head_s.live;
        write_reg_r  <= head_s.dest;
        write_data_r <= head_s.data;
        pc_new_r     <= head_s.pc;
      end else begin
        regwrite_r   <= 1'b0;
      end
    end
  end

  assign bus.md_ready   = md_ready_r;
  assign bus.regwrite   = regwrite_r;
  assign bus.write_reg  = write_reg_r;
  assign bus.write_data = write_data_r;
  assign bus.pc_new     = pc_new_r;
  assign bus.busy       = busy_s;

`ifdef WB_WRITER_TRACE_EN
  // Commit trace, one line per real register write.
  always_ff @(posedge clk) begin
    if (regwrite_r) $display("@%h: $%0d <= %h", pc_new_r, write_reg_r, write_data_r);
  end
`else
  // Trace disabled: no simulation output.
`endif

endmodule
